fp_mult_norm_round: RTL and testbench
=====================================

Name: fp_mult_norm_round

Overview:
- Downstream neighbour of the multiplier's exponent/sign execute stage. Consumes the biased exponent sum, the product sign, the raw 24x24 significand product and the upstream special-case flags.
- Normalizes, rounds to nearest-even, range-checks the exponent and packs an IEEE-754 single-precision result.
- Two-register pipeline with valid/ready flow control; last stage of the FPMult datapath.

Parameters:
- EXP_W, 10, width of signed exponent input (two's complement; holds Ea+Eb-127 range -127..383)
- MAN_W, 48, width of significand product input
- NAN_CODE, 32'h7FC00000, canonical quiet NaN emitted for NaN results

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream operand bundle valid
- in_ready  output  1  block can accept bundle this cycle
- Sp  input  1  product sign
- E  input  EXP_W  signed biased exponent sum
- M  input  MAN_W  significand product (1.x * 1.x, leading one at bit 47 or 46)
- in_zero  input  1  an operand was zero
- in_inf  input  1  an operand was infinity
- in_nan  input  1  an operand was NaN
- P  output  32  packed result
- out_valid  output  1  P and flags valid
- out_ready  input  1  downstream accepts P
- ovf  output  1  overflow occurred
- unf  output  1  underflow occurred (flushed to zero)
- inexact  output  1  rounding discarded nonzero bits

Behaviour:
- Reset (rst=0, async): both stage valid bits 0; out_valid=0, P=0, ovf=unf=inexact=0. Data registers need no reset.
- Handshake:
  - Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready.
  - in_ready = !s1_valid | s1_advance; s1_advance = !s2_valid | out_ready. Combinational in_ready, no other comb path input->output.
  - Outputs hold stable while out_valid & !out_ready.
- Latency 2 cycles with no backpressure; throughput 1/cycle. No bundle dropped or duplicated under any ready pattern.
- Stage 1 (normalize), registered:
  - If M[47]=1: N=M, En=E+1. Else: N=M<<1, En=E.
  - frac=N[46:24], G=N[23], S=|N[22:0]. Sign and special flags carried alongside.
- Stage 2 (round/pack), registered into P/flags:
  - Round up when G & (S | frac[0]). frac+1 carry-out gives frac=0, En+1.
  - inexact = G | S.
  - Range check on the final exponent: En>=255 gives P={Sp,8'hFF,23'h0}, ovf=1, inexact=1. En<=0 gives P={Sp,31'h0}, unf=1 (flush-to-zero, no denormals).
  - Otherwise P={Sp,En[7:0],frac}, ovf=unf=0.
- Special priority, overriding arithmetic and clearing ovf/unf/inexact:
  - in_nan, or in_inf & in_zero: P=NAN_CODE.
  - else in_inf: P={Sp,8'hFF,23'h0}.
  - else in_zero: P={Sp,31'h0}.
- Boundaries:
  - The exponent carry from rounding is included in the overflow check, so an En=254 rounding carry yields inf.
  - Reset asserted mid-operation discards both in-flight bundles immediately.
  - Simultaneous in and out transfer in the same cycle is allowed.

Test Plan:
- 1.5*1.5: E=127, M=48'h900000000000, Sp=0 -> P=32'h40100000 two cycles later, all flags 0.
- Tie rounding: E=127, M[47]=1, N[23]=1, N[22:0]=0, frac[0]=0 -> no increment, inexact=1. Same with frac[0]=1 -> frac+1. Frac all ones with round-up -> frac=0, exponent+1.
- Overflow: E=254, M[47]=1, Sp=1 -> P=32'hFF800000, ovf=1. Underflow: E=0, M[47]=0 -> P=32'h00000000, unf=1.
- Specials: in_inf=1 & in_zero=1 -> P=32'h7FC00000. in_inf=1, Sp=1 -> 32'hFF800000. in_zero=1, Sp=1 -> 32'h80000000, flags 0.
- Backpressure: stream 4 back-to-back bundles, out_ready low for 5 cycles from the first out_valid. in_ready drops once both stages are full, P stays stable, all 4 results emerge in order exactly once.
- Reset: assert rst low with 2 bundles in flight -> out_valid=0 asynchronously. After release, a new bundle appears 2 cycles after acceptance.

Source files
------------

// File: rtl/fp_mult_norm_round.sv
// Final FPMult stage: normalize the 48-bit significand product, round to
// nearest-even, range-check the exponent and pack an IEEE-754 single.
// Two registered stages with valid/ready flow control.
module fp_mult_norm_round #(
  parameter int          EXP_W    = 10,
  parameter int          MAN_W    = 48,
  parameter logic [31:0] NAN_CODE = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Sp,
  input  logic [EXP_W-1:0] E,
  input  logic [MAN_W-1:0] M,
  input  logic             in_zero,
  input  logic             in_inf,
  input  logic             in_nan,
  output logic [31:0]      P,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             unf,
  output logic             inexact
);

  localparam logic signed [EXP_W-1:0] EXP_INF  = EXP_W'(255);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;

  logic s1_advance;

  // stage 1 (normalized) state
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_sign_q, s1_sign_d;
  logic signed [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic [22:0]             s1_frac_q, s1_frac_d;
  logic                    s1_g_q, s1_g_d;
  logic                    s1_s_q, s1_s_d;
  logic                    s1_zero_q, s1_zero_d;
  logic                    s1_inf_q, s1_inf_d;
  logic                    s1_nan_q, s1_nan_d;

  // stage 2 (packed result) state
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] p_q, p_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        inexact_q, inexact_d;

  logic                    round_up;
  logic                    carry;
  logic [22:0]             frac_rnd;
  logic signed [EXP_W-1:0] exp_fin;

  // Handshake: stage 1 may move on whenever stage 2 is empty or draining.
  always_comb begin
    s1_advance = !s2_valid_q | out_ready;
    in_ready   = !s1_valid_q | s1_advance;
  end

  // Stage 1: pick the leading one (bit 47 or 46) and split frac/guard/sticky.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_frac_d  = s1_frac_q;
    s1_g_d     = s1_g_q;
    s1_s_d     = s1_s_q;
    s1_zero_d  = s1_zero_q;
    s1_inf_d   = s1_inf_q;
    s1_nan_d   = s1_nan_q;
    if (in_ready) s1_valid_d = in_valid;
    if (in_valid && in_ready) begin
      s1_sign_d = Sp;
      s1_zero_d = in_zero;
      s1_inf_d  = in_inf;
      s1_nan_d  = in_nan;
      if (M[MAN_W-1]) begin
        s1_exp_d  = E + {{(EXP_W-1){1'b0}}, 1'b1};
        s1_frac_d = M[MAN_W-2 -: 23];
        s1_g_d    = M[MAN_W-25];
        s1_s_d    = |M[MAN_W-26:0];
      end else begin
        s1_exp_d  = E;
        s1_frac_d = M[MAN_W-3 -: 23];
        s1_g_d    = M[MAN_W-26];
        s1_s_d    = |M[MAN_W-27:0];
      end
    end
  end

  // Stage 2: round-to-nearest-even, fold carry into exponent, range check, pack.
  always_comb begin
    round_up          = s1_g_q & (s1_s_q | s1_frac_q[0]);
    {carry, frac_rnd} = {1'b0, s1_frac_q} + {23'd0, round_up};
    exp_fin           = s1_exp_q + {{(EXP_W-1){1'b0}}, carry};
    s2_valid_d = s2_valid_q;
    p_d        = p_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    inexact_d  = inexact_q;
    if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        inexact_d = s1_g_q | s1_s_q;
        if (s1_nan_q || (s1_inf_q && s1_zero_q)) begin
          p_d       = NAN_CODE;
          inexact_d = 1'b0;
        end else if (s1_inf_q) begin
          p_d       = {s1_sign_q, 8'hFF, 23'h0};
          inexact_d = 1'b0;
        end else if (s1_zero_q) begin
          p_d       = {s1_sign_q, 31'h0};
          inexact_d = 1'b0;
        end else if (exp_fin >= EXP_INF) begin
          p_d       = {s1_sign_q, 8'hFF, 23'h0};
          ovf_d     = 1'b1;
          inexact_d = 1'b1;
        end else if (exp_fin <= EXP_ZERO) begin
          // no denormal support: flush to signed zero
          p_d   = {s1_sign_q, 31'h0};
          unf_d = 1'b1;
        end else begin
          p_d = {s1_sign_q, exp_fin[7:0], frac_rnd};
        end
      end
    end
  end

  // Control and output registers; reset drops both in-flight bundles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      p_q        <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      p_q        <= p_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      inexact_q  <= inexact_d;
    end
  end

  // Stage 1 data registers carry no reset; they are qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    s1_sign_q <= s1_sign_d;
    s1_exp_q  <= s1_exp_d;
    s1_frac_q <= s1_frac_d;
    s1_g_q    <= s1_g_d;
    s1_s_q    <= s1_s_d;
    s1_zero_q <= s1_zero_d;
    s1_inf_q  <= s1_inf_d;
    s1_nan_q  <= s1_nan_d;
  end

  assign P         = p_q;
  assign out_valid = s2_valid_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_mult_norm_round.sv
// Bench for fp_mult_norm_round: directed corner cases, randomized streaming
// against an integer rounding model, backpressure and mid-flight reset.
module tb_fp_mult_norm_round;

  typedef struct {
    bit          sp;
    int          e;
    logic [47:0] m;
    bit          z;
    bit          inf;
    bit          nan;
  } bundle_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        Sp;
  logic [9:0]  E;
  logic [47:0] M;
  logic        in_zero, in_inf, in_nan;
  logic [31:0] P;
  logic        out_valid;
  logic        out_ready;
  logic        ovf, unf, inexact;

  int checks   = 0;
  int failures = 0;

  logic [34:0] exp_q[$];

  fp_mult_norm_round #(.EXP_W(10), .MAN_W(48), .NAN_CODE(32'h7FC00000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Sp(Sp), .E(E), .M(M), .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
    .P(P), .out_valid(out_valid), .out_ready(out_ready),
    .ovf(ovf), .unf(unf), .inexact(inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got time-out expected finish");
    $fatal(1, "watchdog");
  end

  // Reference: value = M * 2^(E-127-46); keep the top 24 bits, round the
  // remainder to nearest-even, renormalize on mantissa overflow.
  function automatic logic [34:0] model(bundle_t b);
    int sh, ex;
    longint unsigned mant, rem, half;
    bit inx;
    if (b.nan || (b.inf && b.z)) return {3'b000, 32'h7FC00000};
    if (b.inf) return {3'b000, b.sp, 8'hFF, 23'h0};
    if (b.z)   return {3'b000, b.sp, 31'h0};
    sh   = b.m[47] ? 24 : 23;
    ex   = b.e + (b.m[47] ? 1 : 0);
    mant = 64'(b.m) >> sh;
    rem  = 64'(b.m) & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    inx  = (rem != 0);
    if (rem > half || (rem == half && mant[0])) mant++;
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      ex++;
    end
    if (ex >= 255) return {3'b101, b.sp, 8'hFF, 23'h0};
    if (ex <= 0)   return {2'b01, inx, b.sp, 31'h0};
    return {2'b00, inx, b.sp, 8'(ex), 23'(mant)};
  endfunction

  function automatic bundle_t mk(bit sp, int e, logic [47:0] m, bit z, bit inf, bit nan);
    bundle_t b;
    b.sp = sp; b.e = e; b.m = m; b.z = z; b.inf = inf; b.nan = nan;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    logic [63:0] r;
    r    = {$urandom, $urandom};
    b.sp = 1'($urandom_range(0, 1));
    b.e  = int'($urandom_range(0, 275)) - 10;
    if ($urandom_range(0, 1) == 1) b.m = {1'b1, r[46:0]};
    else                           b.m = {2'b01, r[45:0]};
    if ($urandom_range(0, 7) == 0) begin
      if (b.m[47]) begin b.m[23] = 1'b1; b.m[22:0] = '0; end
      else         begin b.m[22] = 1'b1; b.m[21:0] = '0; end
    end
    b.z   = ($urandom_range(0, 15) == 0);
    b.inf = ($urandom_range(0, 15) == 0);
    b.nan = ($urandom_range(0, 15) == 0);
    return b;
  endfunction

  task automatic set_bundle(bundle_t b);
    Sp = b.sp; E = 10'(b.e); M = b.m;
    in_zero = b.z; in_inf = b.inf; in_nan = b.nan;
  endtask

  // Called just after a falling edge with inputs set; samples handshakes and
  // outputs 1 time unit later, then advances to the next falling edge.
  task automatic tick(output bit fi, output bit fo, output bit rdy, output logic [34:0] obs);
    #1;
    fi  = in_valid & in_ready;
    fo  = out_valid & out_ready;
    rdy = in_ready;
    obs = {ovf, unf, inexact, P};
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    if (out_valid !== 1'b0) failures++;
    checks++; if (P !== 32'h0) begin failures++; $display("FAIL reset_P: got %h expected 00000000", P); end
    checks++; if ({ovf, unf, inexact} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b expected 000", {ovf, unf, inexact});
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    bundle_t     db[11];
    logic [34:0] dx[11];
    bit fi, fo, rdy;
    logic [34:0] obs, keep;
    int lat;
    db[0]  = mk(0, 127, 48'h900000000000, 0, 0, 0); dx[0]  = {3'b000, 32'h40100000};
    db[1]  = mk(0, 127, 48'h800000800000, 0, 0, 0); dx[1]  = {3'b001, 32'h40000000};
    db[2]  = mk(0, 127, 48'h800001800000, 0, 0, 0); dx[2]  = {3'b001, 32'h40000002};
    db[3]  = mk(0, 127, 48'hFFFFFF800000, 0, 0, 0); dx[3]  = {3'b001, 32'h40800000};
    db[4]  = mk(1, 254, 48'h800000000000, 0, 0, 0); dx[4]  = {3'b101, 32'hFF800000};
    db[5]  = mk(0, 0,   48'h400000000000, 0, 0, 0); dx[5]  = {3'b010, 32'h00000000};
    db[6]  = mk(0, 253, 48'hFFFFFF800000, 0, 0, 0); dx[6]  = {3'b101, 32'h7F800000};
    db[7]  = mk(0, 127, 48'h900000000000, 1, 1, 0); dx[7]  = {3'b000, 32'h7FC00000};
    db[8]  = mk(1, 127, 48'h900000000000, 0, 1, 0); dx[8]  = {3'b000, 32'hFF800000};
    db[9]  = mk(1, 127, 48'hFFFFFF800000, 1, 0, 0); dx[9]  = {3'b000, 32'h80000000};
    db[10] = mk(1, 300, 48'h800000000000, 1, 0, 1); dx[10] = {3'b000, 32'h7FC00000};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_bundle(db[i]);
      in_valid = 1'b1;
      tick(fi, fo, rdy, obs);
      in_valid = 1'b0;
      checks++;
      if (!fi) begin failures++; $display("FAIL dir_accept[%0d]: got in_ready=%b expected 1", i, rdy); end
      lat  = 0;
      keep = '0;
      for (int c = 1; c <= 6 && lat == 0; c++) begin
        tick(fi, fo, rdy, obs);
        if (fo) begin lat = c; keep = obs; end
      end
      checks++;
      if (lat != 2) begin failures++; $display("FAIL dir_latency[%0d]: got %0d expected 2", i, lat); end
      checks++;
      if (keep !== dx[i]) begin
        failures++;
        $display("FAIL dir_result[%0d]: got flags=%b P=%h expected flags=%b P=%h",
                 i, keep[34:32], keep[31:0], dx[i][34:32], dx[i][31:0]);
      end
    end
  endtask

  task automatic test_random(int n);
    int sent = 0, got = 0, budget = 0;
    bit fi, fo, rdy;
    logic [34:0] obs, ex;
    bundle_t b;
    b = rand_bundle();
    exp_q.delete();
    in_valid = 1'b0;
    while (got < n && budget < 40 * n) begin
      if (!in_valid && sent < n && $urandom_range(0, 3) != 0) begin
        set_bundle(b);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick(fi, fo, rdy, obs);
      if (fi) begin
        exp_q.push_back(model(b));
        sent++;
        b = rand_bundle();
        in_valid = 1'b0;
      end
      if (fo) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_extra: got P=%h expected no output", obs[31:0]);
        end else begin
          ex = exp_q.pop_front();
          if (obs !== ex) begin
            failures++;
            $display("FAIL rand_result[%0d]: got flags=%b P=%h expected flags=%b P=%h",
                     got, obs[34:32], obs[31:0], ex[34:32], ex[31:0]);
          end
        end
      end
      budget++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != n) begin failures++; $display("FAIL rand_count: got %0d expected %0d", got, n); end
  endtask

  task automatic test_backpressure();
    bundle_t bs[4];
    int idx = 0, got = 0, stall = 0;
    bit seen = 0, blocked = 0, fi, fo, rdy, held;
    logic [34:0] obs, ex;
    for (int i = 0; i < 4; i++) bs[i] = rand_bundle();
    bs[0].z = 0; bs[0].inf = 0; bs[0].nan = 0; bs[0].e = 100;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (idx < 4) begin set_bundle(bs[idx]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      if (!seen && out_valid) begin seen = 1; stall = 5; end
      out_ready = (stall == 0);
      if (stall > 0) stall--;
      held = out_valid & !out_ready;
      tick(fi, fo, rdy, obs);
      if (in_valid && !rdy) blocked = 1;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || {ovf, unf, inexact, P} !== obs) begin
          failures++;
          $display("FAIL bp_hold: got valid=%b P=%h expected valid=1 P=%h", out_valid, P, obs[31:0]);
        end
      end
      if (fi) idx++;
      if (fo) begin
        checks++;
        if (got >= 4) begin
          failures++; $display("FAIL bp_extra: got P=%h expected no output", obs[31:0]);
        end else begin
          ex = model(bs[got]);
          if (obs !== ex) begin
            failures++;
            $display("FAIL bp_result[%0d]: got flags=%b P=%h expected flags=%b P=%h",
                     got, obs[34:32], obs[31:0], ex[34:32], ex[31:0]);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++; if (got != 4) begin failures++; $display("FAIL bp_count: got %0d expected 4", got); end
    checks++; if (!blocked) begin failures++; $display("FAIL bp_in_ready_drop: got never-low expected low"); end
  endtask

  task automatic test_reset_midflight();
    bit fi, fo, rdy;
    logic [34:0] obs;
    int lat = 0, outs = 0;
    out_ready = 1'b1;
    set_bundle(mk(0, 130, 48'hC00000000000, 0, 0, 0));
    in_valid = 1'b1;
    tick(fi, fo, rdy, obs);
    set_bundle(mk(1, 120, 48'hA00000000000, 0, 0, 0));
    tick(fi, fo, rdy, obs);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_inflight: got valid=%b expected 1", out_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
    checks++; if ({ovf, unf, inexact, P} !== 35'h0) begin
      failures++; $display("FAIL rst_async_data: got P=%h expected 00000000", P);
    end
    @(negedge clk);
    rst = 1'b1;
    set_bundle(mk(0, 127, 48'h900000000000, 0, 0, 0));
    in_valid = 1'b1;
    tick(fi, fo, rdy, obs);
    in_valid = 1'b0;
    checks++; if (fo) begin failures++; $display("FAIL rst_stale: got P=%h expected no output", obs[31:0]); end
    for (int c = 1; c <= 6; c++) begin
      tick(fi, fo, rdy, obs);
      if (fo) begin
        outs++;
        if (lat == 0) lat = c;
        checks++;
        if (obs !== {3'b000, 32'h40100000}) begin
          failures++; $display("FAIL rst_new_result: got P=%h expected 40100000", obs[31:0]);
        end
      end
    end
    checks++; if (lat != 2) begin failures++; $display("FAIL rst_new_latency: got %0d expected 2", lat); end
    checks++; if (outs != 1) begin failures++; $display("FAIL rst_new_count: got %0d expected 1", outs); end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0;
    Sp = 1'b0; E = '0; M = '0; in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0;
    test_reset();
    test_directed();
    test_random(300);
    test_backpressure();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
